alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with ARM-style NZCV flags and valid/ready
//            handshakes. Define ALU_MC_MUL_EN to include the iterative
//            shift-add multiplier (opcode 8) and its BUSY state.
// Revision : 1.0  initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int c_AW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic [c_AW-1:0]  w_amt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic [WIDTH:0]   w_asr;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_def;

  // Shifts carry one extra bit so the last bit shifted out lands at a fixed position.
  assign w_amt = b[c_AW-1:0];
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};
  assign w_lsl = {1'b0, a} << w_amt;
  assign w_lsr = {a, 1'b0} >> w_amt;
  assign w_asr = $unsigned($signed({a, 1'b0}) >>> w_amt);

  always_comb begin
    w_res = '0;
    w_c   = r_flags[1];
    w_v   = r_flags[0];
    w_def = 1'b1;
    case (opcode)
      4'd0: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = ~w_sub[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: w_res = a & b;
      4'd3: w_res = a | b;
      4'd4: w_res = a ^ b;
      4'd5: begin
        w_res = w_lsl[WIDTH-1:0];
        if (w_amt != '0) w_c = w_lsl[WIDTH];
      end
      4'd6: begin
        w_res = w_lsr[WIDTH:1];
        if (w_amt != '0) w_c = w_lsr[0];
      end
      4'd7: begin
        w_res = w_asr[WIDTH:1];
        if (w_amt != '0) w_c = w_asr[0];
      end
      default: w_def = 1'b0;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  localparam int c_CW = c_AW + 1;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [c_CW-1:0]  r_cnt;
  logic             r_sf;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_flags  <= 4'b0000;
`ifdef ALU_MC_MUL_EN
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_MC_MUL_EN
            if (opcode == 4'd8) begin
              r_mcand  <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_sf     <= set_flags;
              r_state  <= S_BUSY;
            end else begin
`else
            begin
`endif
              r_result <= w_res;
              if (set_flags && w_def)
                r_flags <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
              r_state  <= S_DONE;
            end
          end
        end
`ifdef ALU_MC_MUL_EN
        S_BUSY: begin
          // WIDTH iterations, then one more edge to publish the product.
          if (r_cnt == c_CW'(WIDTH)) begin
            r_result <= r_acc;
            if (r_sf)
              r_flags <= {r_acc[WIDTH-1], (r_acc == '0), r_flags[1:0]};
            r_state  <= S_DONE;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_CW'(1);
          end
        end
`endif
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule
`default_nettype wire
